line_fill_arbiter: RTL and testbench



---
 rtl/line_fill_arbiter.sv | 173 +++++++++++++++++
 tb/tb_line_fill_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_arbiter.sv
// Two-port cache line-fill arbiter: serialises instruction/data line reads and
// data line writes onto a 32-bit word memory port and reassembles read lines.
module line_fill_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    p0_req,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  output logic                    p0_gnt,
  output logic                    p0_rvalid,
  output logic [LINE_BYTES*8-1:0] p0_rdata,
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [LINE_BYTES*8-1:0] p1_wdata,
  output logic                    p1_gnt,
  output logic                    p1_rvalid,
  output logic [LINE_BYTES*8-1:0] p1_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic                    mem_ack,
  input  logic [31:0]             mem_rdata
);

  localparam int WORDS_PER_LINE = LINE_BYTES / 4;
  localparam int LINE_W         = LINE_BYTES * 8;
  localparam int BEAT_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    port_q, port_d;          // 0 = instruction side, 1 = data side
  logic                    we_q, we_d;
  logic                    last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   line_addr_q, line_addr_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic                    p0_gnt_q, p0_gnt_d, p1_gnt_q, p1_gnt_d;
  logic                    p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic [LINE_W-1:0]       p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic                    mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic                    win;
  logic [ADDR_WIDTH-1:0]   sel_addr;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    beat_d       = beat_q;
    port_d       = port_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    line_addr_d  = line_addr_q;
    line_d       = line_q;
    p0_gnt_d     = 1'b0;
    p1_gnt_d     = 1'b0;
    p0_rvalid_d  = 1'b0;
    p1_rvalid_d  = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    win          = 1'b0;
    sel_addr     = p0_addr;

    case (state_q)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          // On a tie the port that was not served last wins.
          win          = (p0_req && p1_req) ? ~last_grant_q : p1_req;
          sel_addr     = win ? p1_addr : p0_addr;
          port_d       = win;
          last_grant_d = win;
          we_d         = win & p1_we;
          line_addr_d  = sel_addr & ~OFFSET_MASK;
          line_d       = we_d ? p1_wdata : '0;
          beat_d       = '0;
          p0_gnt_d     = ~win;
          p1_gnt_d     = win;
          mem_req_d    = 1'b1;
          mem_we_d     = we_d;
          mem_addr_d   = line_addr_d;
          mem_wdata_d  = line_d[31:0];
          state_d      = S_BURST;
        end
      end

      S_BURST: begin
        if (mem_ack) begin
          if (!we_q) line_d[32*int'(beat_q) +: 32] = mem_rdata;
          if (beat_q == LAST_BEAT) begin
            mem_req_d   = 1'b0;
            p0_rvalid_d = ~port_q;
            p1_rvalid_d = port_q;
            if (port_q) p1_rdata_d = line_d;
            else        p0_rdata_d = line_d;
            state_d     = S_RESP;
          end else begin
            beat_d      = beat_q + 1'b1;
            mem_addr_d  = line_addr_q + (ADDR_WIDTH'(beat_d) << 2);
            mem_wdata_d = line_q[32*int'(beat_d) +: 32];
          end
        end
      end

      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the line buffer is plain flops rather than a RAM, so it resets with the control state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      line_addr_q  <= '0;
      line_q       <= '0;
      p0_gnt_q     <= 1'b0;
      p1_gnt_q     <= 1'b0;
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q      <= state_d;
      beat_q       <= beat_d;
      port_q       <= port_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      line_addr_q  <= line_addr_d;
      line_q       <= line_d;
      p0_gnt_q     <= p0_gnt_d;
      p1_gnt_q     <= p1_gnt_d;
      p0_rvalid_q  <= p0_rvalid_d;
      p1_rvalid_q  <= p1_rvalid_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign p0_gnt    = p0_gnt_q;
  assign p1_gnt    = p1_gnt_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Bench for line_fill_arbiter: directed literal scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_line_fill_arbiter;

  localparam int AW = 32;
  localparam int LB = 16;
  localparam int W  = LB / 4;
  localparam int LW = LB * 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          p0_req = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [LW-1:0] p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [LW-1:0] p0_rdata, p1_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  line_fill_arbiter #(.ADDR_WIDTH(AW), .LINE_BYTES(LB)) dut (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] mem [256];

  // Bench knobs
  bit hold_reqs = 0, auto_req = 0, rand_ack = 0;
  int ack_delay = 0, wait_cnt = 0;

  // Transaction-level model: the current transfer and what the outputs must show
  bit            m_busy = 0, m_resp = 0, m_we = 0;
  int            m_port = 0, m_k = 0, m_last = 1;
  logic [AW-1:0] m_base = '0;
  logic [LW-1:0] m_line = '0;
  logic          exp_g0 = 0, exp_g1 = 0, exp_rv0 = 0, exp_rv1 = 0, exp_mreq = 0, exp_mwe = 0;
  logic [LW-1:0] exp_rd0 = '0, exp_rd1 = '0;
  logic [AW-1:0] exp_maddr = '0;
  logic [31:0]   exp_mwdata = '0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advances the model by one clock given the inputs about to be sampled.
  task automatic model_step();
    bit resp_next = 0;
    int win;
    exp_g0 = 0; exp_g1 = 0; exp_rv0 = 0; exp_rv1 = 0;
    if (!rstn) begin
      m_busy = 0; m_resp = 0; m_last = 1;
      exp_rd0 = '0; exp_rd1 = '0; exp_mreq = 0;
      return;
    end
    if (m_busy) begin
      if (mem_ack) begin
        if (!m_we) m_line[32*m_k +: 32] = mem_rdata;
        m_k++;
        if (m_k == W) begin m_busy = 0; resp_next = 1; end
      end
    end else if (!m_resp && (p0_req || p1_req)) begin
      if (p0_req && p1_req) win = (m_last == 0) ? 1 : 0;
      else                  win = p1_req ? 1 : 0;
      m_last = win; m_port = win; m_busy = 1; m_k = 0;
      m_base = (win == 1 ? p1_addr : p0_addr) & ~32'(LB - 1);
      m_we   = (win == 1) && p1_we;
      m_line = m_we ? p1_wdata : '0;
      if (win == 0) exp_g0 = 1; else exp_g1 = 1;
    end
    m_resp = resp_next;
    if (resp_next) begin
      if (m_port == 0) begin exp_rv0 = 1; exp_rd0 = m_line; end
      else             begin exp_rv1 = 1; exp_rd1 = m_line; end
    end
    exp_mreq = m_busy;
    if (m_busy) begin
      exp_maddr  = m_base + 32'(4 * m_k);
      exp_mwe    = m_we;
      exp_mwdata = m_line[32*m_k +: 32];
    end
  endtask

  // One clock: drive requesters and memory, step the model, then compare at the negedge.
  task automatic tick();
    int idx;
    if (!hold_reqs) begin
      if (exp_g0) p0_req = 0;
      if (exp_g1) p1_req = 0;
    end
    if (auto_req) begin
      if (!p0_req && $urandom_range(3) == 0) begin p0_req = 1; p0_addr = $urandom; end
      if (!p1_req && $urandom_range(3) == 0) begin
        p1_req = 1; p1_we = 1'($urandom_range(1)); p1_addr = $urandom;
        p1_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    idx = int'(exp_maddr[9:2]);
    mem_ack = 0; mem_rdata = $urandom;
    if (rstn && exp_mreq) begin
      if (rand_ack) mem_ack = ($urandom_range(99) < 60);
      else          mem_ack = (wait_cnt == ack_delay);
      wait_cnt = mem_ack ? 0 : wait_cnt + 1;
      if (mem_ack) begin
        if (exp_mwe) mem[idx] = exp_mwdata;
        else         mem_rdata = mem[idx];
      end
    end else wait_cnt = 0;
    model_step();
    @(negedge clk);
    cyc++;
    check("p0_gnt", p0_gnt, exp_g0);
    check("p1_gnt", p1_gnt, exp_g1);
    check("p0_rvalid", p0_rvalid, exp_rv0);
    check("p1_rvalid", p1_rvalid, exp_rv1);
    check("p0_rdata", p0_rdata, exp_rd0);
    check("p1_rdata", p1_rdata, exp_rd1);
    check("mem_req", mem_req, exp_mreq);
    check("gnt_rvalid_excl", (p0_gnt | p1_gnt) & (p0_rvalid | p1_rvalid), 0);
    if (exp_mreq) begin
      check("mem_addr", mem_addr, exp_maddr);
      check("mem_we", mem_we, exp_mwe);
      if (exp_mwe) check("mem_wdata", mem_wdata, exp_mwdata);
    end
  endtask

  initial begin
    int t0, n;
    bit seen;
    int order [4];
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    // Reset state
    repeat (3) tick();
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_p0_rdata", p0_rdata, 0);
    rstn = 1;
    tick();

    // p0 line read at 0x100, zero-wait memory
    mem[8'h40] = 32'h11111111; mem[8'h41] = 32'h22222222;
    mem[8'h42] = 32'h33333333; mem[8'h43] = 32'h44444444;
    p0_addr = 32'h100; p0_req = 1; t0 = cyc;
    tick();
    check("A_gnt", p0_gnt, 1);
    check("A_addr0", mem_addr, 32'h100);
    for (int k = 1; k < W; k++) begin
      tick();
      check("A_addr", mem_addr, 32'h100 + 32'(4 * k));
    end
    tick();
    check("A_rvalid", p0_rvalid, 1);
    check("A_latency", cyc - t0, 5);
    check("A_rdata", p0_rdata, 128'h44444444_33333333_22222222_11111111);
    tick();

    // Unaligned address ignores the offset bits
    p0_addr = 32'h107; p0_req = 1;
    tick();
    check("E_addr0", mem_addr, 32'h100);
    repeat (5) tick();

    // p1 line write at 0x200
    p1_addr = 32'h200; p1_we = 1; p1_req = 1;
    p1_wdata = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    tick();
    check("C_gnt", p1_gnt, 1);
    check("C_we", mem_we, 1);
    check("C_addr0", mem_addr, 32'h200);
    check("C_wdata0", mem_wdata, 32'hAAAAAAAA);
    repeat (W - 1) tick();
    check("C_addr3", mem_addr, 32'h20C);
    check("C_wdata3", mem_wdata, 32'hDDDDDDDD);
    tick();
    check("C_rvalid", p1_rvalid, 1);
    check("C_rdata", p1_rdata, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    tick();

    // Memory acks each beat three cycles after it is presented
    ack_delay = 3; p0_addr = 32'h100; p0_req = 1; t0 = cyc; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (cyc - t0 <= 4) check("D_hold_addr", mem_addr, 32'h100);
      if (p0_rvalid) seen = 1;
    end
    check("D_rvalid_seen", seen, 1);
    check("D_latency", cyc - t0, 17);
    check("D_rdata", p0_rdata, 128'h44444444_33333333_22222222_11111111);
    tick();
    ack_delay = 0;

    // Both ports requesting continuously after reset: strict alternation from p0
    rstn = 0; tick(); tick(); rstn = 1; tick();
    p0_addr = 32'h100; p1_addr = 32'h300; p1_we = 0;
    hold_reqs = 1; p0_req = 1; p1_req = 1; n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      tick();
      check("tie_both_gnt", p0_gnt & p1_gnt, 0);
      if (p0_gnt && n < 4) begin order[n] = 0; n++; end
      if (p1_gnt && n < 4) begin order[n] = 1; n++; end
    end
    check("tie_grant_count", n, 4);
    check("tie_order0", order[0], 0);
    check("tie_order1", order[1], 1);
    check("tie_order2", order[2], 0);
    check("tie_order3", order[3], 1);
    hold_reqs = 0;
    repeat (14) tick();

    // Reset pulsed during beat 2 discards the transfer
    p0_addr = 32'h100; p0_req = 1;
    repeat (3) tick();
    rstn = 0;
    #1;
    check("rst_mem_req_async", mem_req, 0);
    tick(); tick();
    rstn = 1;
    repeat (3) begin
      tick();
      check("rst_no_rvalid", p0_rvalid | p1_rvalid, 0);
    end
    p0_req = 1; p1_req = 1; p1_addr = 32'h300; p1_we = 0;
    tick();
    check("rst_tie_p0", p0_gnt, 1);
    check("rst_tie_p1", p1_gnt, 0);
    repeat (14) tick();

    // Randomized traffic with random memory stalls
    auto_req = 1; rand_ack = 1;
    repeat (1500) tick();
    auto_req = 0;
    repeat (100) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
